// File: rtl/aud_pkg.sv
// Shared audio-path types and constants for the looper blocks.
package aud_pkg;

  localparam int AUD_DATA_W = 16;

  localparam logic signed [AUD_DATA_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [AUD_DATA_W-1:0] SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    READ  = 2'd2
  } loop_rd_state_e;

endpackage

// File: rtl/sat_add.sv
// Signed W-bit adder that clamps to the most positive / most negative code on overflow.
module sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum
);

  logic signed [W:0] sum_w;

  always_comb begin
    sum_w = {i_a[W-1], i_a} + {i_b[W-1], i_b};
    // Overflow shows up as the two top bits of the widened sum disagreeing.
    if (sum_w[W] != sum_w[W-1]) begin
      o_sum = sum_w[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      o_sum = sum_w[W-1:0];
    end
  end

endmodule

// File: rtl/loop_sram_reader.sv
// Loop playback: one SRAM read per audio frame, wrapping at the recorded length.
// Optional live-input mixing is built when LOOP_MIX_EN is defined.
module loop_sram_reader
  import aud_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int DATA_W    = AUD_DATA_W,
  parameter int READ_WAIT = 2
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_sample_valid,
  input  logic [ADDR_W-1:0] i_loop_len,
  input  logic [DATA_W-1:0] i_live_data,
  input  logic [DATA_W-1:0] i_SRAM_DQ,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_wrap,
  output loop_rd_state_e    o_dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(READ_WAIT - 1);

  loop_rd_state_e    state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ce_n_q, ce_n_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  logic              start_ok;
  logic              read_done;
  logic              last_word;
  logic [DATA_W-1:0] read_word;

  assign start_ok  = i_start && (i_loop_len != '0);
  assign read_done = (state_q == READ) && (cnt_q == '0);
  assign last_word = (ptr_q == len_q - 1'b1);

`ifdef LOOP_MIX_EN
  logic [DATA_W-1:0] live_q, live_d;
  logic              pend_q, pend_d;
  logic              idle_fire;
  logic [DATA_W-1:0] mix_sum;

  assign idle_fire = (state_q == IDLE) && pend_q && (cnt_q == '0);

  sat_add #(.W(DATA_W)) u_sat_add (
    .i_a   (i_SRAM_DQ),
    .i_b   (live_q),
    .o_sum (mix_sum)
  );

  assign read_word = mix_sum;
`else
  logic unused_live;
  assign unused_live = ^i_live_data;
  assign read_word   = i_SRAM_DQ;
`endif

  // State register
  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef LOOP_MIX_EN
      live_q  <= '0;
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      ce_n_q  <= ce_n_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
`ifdef LOOP_MIX_EN
      live_q  <= live_d;
      pend_q  <= pend_d;
`endif
    end
  end

  // Next-state logic; stop beats start, and a zero-length start is ignored everywhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
`ifdef LOOP_MIX_EN
    live_d  = live_q;
    pend_d  = pend_q;
`endif
    if (i_stop) begin
      state_d = IDLE;
      ptr_d   = '0;
`ifdef LOOP_MIX_EN
      pend_d  = 1'b0;
`endif
    end else if (start_ok) begin
      state_d = ARMED;
      ptr_d   = '0;
      len_d   = i_loop_len;
`ifdef LOOP_MIX_EN
      pend_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef LOOP_MIX_EN
          if (i_sample_valid) begin
            live_d = i_live_data;
            pend_d = 1'b1;
            cnt_d  = CNT_LOAD;
          end else if (pend_q) begin
            if (cnt_q == '0) pend_d = 1'b0;
            else             cnt_d  = cnt_q - 1'b1;
          end
`endif
        end
        ARMED: begin
          if (i_sample_valid) begin
            state_d = READ;
            cnt_d   = CNT_LOAD;
`ifdef LOOP_MIX_EN
            live_d  = i_live_data;
`endif
          end
        end
        READ: begin
          if (cnt_q == '0) begin
            state_d = ARMED;
            ptr_d   = last_word ? '0 : ptr_q + 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic (registered outputs' next values)
  always_comb begin
    addr_d  = addr_q;
    ce_n_d  = ce_n_q;
    data_d  = data_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (i_stop) begin
      ce_n_d = 1'b1;
      data_d = '0;
    end else if (start_ok) begin
      ce_n_d = 1'b1;
    end else begin
      if ((state_q == ARMED) && i_sample_valid) begin
        addr_d = ptr_q;
        ce_n_d = 1'b0;
      end
      if (read_done) begin
        ce_n_d  = 1'b1;
        data_d  = read_word;
        valid_d = 1'b1;
        wrap_d  = last_word;
      end
`ifdef LOOP_MIX_EN
      if (idle_fire) begin
        data_d  = live_q;
        valid_d = 1'b1;
      end
`endif
    end
  end

  assign o_SRAM_ADDR = addr_q;
  assign o_SRAM_CE_N = ce_n_q;
  assign o_SRAM_OE_N = ce_n_q;
  assign o_SRAM_LB_N = ce_n_q;
  assign o_SRAM_UB_N = ce_n_q;
  assign o_SRAM_WE_N = 1'b1;
  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_wrap      = wrap_q;
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_loop_sram_reader.sv
// Directed bench for loop_sram_reader with an SRAM model and an expected-output queue.
module tb_loop_sram_reader;
  import aud_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          sv = 1'b0;
  logic [AW-1:0] loop_len = '0;
  logic [DW-1:0] live = '0;
  logic [DW-1:0] sram_dq;
  logic [AW-1:0] addr;
  logic          ce_n, oe_n, we_n, lb_n, ub_n;
  logic [DW-1:0] data;
  logic          valid, busy, wrap;
  loop_rd_state_e dbg_state;

  logic [DW-1:0] mem [16];
  logic [16:0]   exp_q [$];
  int            cyc_q [$];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign sram_dq = (!ce_n && !oe_n && !lb_n && !ub_n) ? mem[addr[3:0]] : 16'hDEAD;

  loop_sram_reader #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(RW)) dut (
    .i_AUD_BCLK     (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_stop         (stop),
    .i_sample_valid (sv),
    .i_loop_len     (loop_len),
    .i_live_data    (live),
    .i_SRAM_DQ      (sram_dq),
    .o_SRAM_ADDR    (addr),
    .o_SRAM_CE_N    (ce_n),
    .o_SRAM_OE_N    (oe_n),
    .o_SRAM_WE_N    (we_n),
    .o_SRAM_LB_N    (lb_n),
    .o_SRAM_UB_N    (ub_n),
    .o_data         (data),
    .o_valid        (valid),
    .o_busy         (busy),
    .o_wrap         (wrap),
    .o_dbg_state    (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every o_valid pops one expected word and its due cycle.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(valid), 32'd0);
      end else begin
        logic [16:0] e;
        int          c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("data", 32'(data), 32'(e[15:0]));
        check("wrap", 32'(wrap), 32'(e[16]));
        check("latency", 32'(cyc), 32'(c));
      end
    end else if (rst_n && wrap) begin
      check("wrap_without_valid", 32'(wrap), 32'd0);
    end
  end

  task automatic pulse_start(input logic [AW-1:0] len);
    @(negedge clk);
    loop_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // kind: 1 = a read is expected, 2 = frame arrives while idle
  task automatic frame(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit w);
    @(negedge clk);
    if (kind == 1) begin
      exp_q.push_back({w, d});
      cyc_q.push_back(cyc + RW + 1);
    end
`ifdef LOOP_MIX_EN
    else if (kind == 2) begin
      exp_q.push_back({1'b0, live});
      cyc_q.push_back(cyc + RW + 1);
    end
`endif
    sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    if (kind == 1) begin
      check("ce_active", 32'(ce_n), 32'd0);
      check("addr", 32'(addr), 32'(a));
    end else begin
      check("ce_idle", 32'(ce_n), 32'd1);
    end
    repeat (RW + 3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'(i * 7 + 3);
    mem[0] = 16'd100; mem[1] = 16'd200; mem[2] = 16'd300; mem[3] = 16'd400;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_ce", 32'(ce_n), 32'd1);
    check("rst_oe", 32'(oe_n), 32'd1);
    check("rst_we", 32'(we_n), 32'd1);
    check("rst_lb", 32'(lb_n), 32'd1);
    check("rst_ub", 32'(ub_n), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Ten frames over a four-word loop
    pulse_start(20'd4);
    check("busy_after_start", 32'(busy), 32'd1);
    check("state_armed", 32'(dbg_state), 32'(ARMED));
    for (int i = 0; i < 10; i++) frame(1, 20'(i % 4), mem[i % 4], (i % 4) == 3);
    check("drain_t1", 32'(exp_q.size()), 32'd0);
    check("we_const", 32'(we_n), 32'd1);

    // Zero-length start is ignored
    pulse_stop();
    check("stop_data", 32'(data), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    pulse_start(20'd0);
    check("len0_busy", 32'(busy), 32'd0);
    frame(2, '0, '0, 1'b0);
    check("len0_busy_after", 32'(busy), 32'd0);

    // Stop during READ aborts the read and silences o_data
    pulse_start(20'd4);
    frame(1, 20'd0, mem[0], 1'b0);
    @(negedge clk);
    sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    check("abort_in_read", 32'(dbg_state), 32'(READ));
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(data), 32'd0);
    check("abort_ce", 32'(ce_n), 32'd1);
    repeat (RW + 3) @(negedge clk);
    pulse_start(20'd4);
    frame(1, 20'd0, mem[0], 1'b0);

    // Start and stop together: stop wins
    @(negedge clk);
    loop_len = 20'd4;
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("start_stop_busy", 32'(busy), 32'd0);
    frame(2, '0, '0, 1'b0);

    // Single-word loop wraps on every output
    pulse_start(20'd1);
    for (int i = 0; i < 3; i++) frame(1, 20'd0, mem[0], 1'b1);

    // Restart while busy re-latches the length and restarts at address 0
    pulse_start(20'd4);
    frame(1, 20'd0, mem[0], 1'b0);
    pulse_start(20'd2);
    frame(1, 20'd0, mem[0], 1'b0);
    frame(1, 20'd1, mem[1], 1'b1);
    frame(1, 20'd0, mem[0], 1'b0);

    // A frame arriving during READ is dropped and the pointer advances once
    pulse_start(20'd4);
    @(negedge clk);
    exp_q.push_back({1'b0, mem[0]});
    cyc_q.push_back(cyc + RW + 1);
    sv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sv = 1'b0;
    repeat (RW + 3) @(negedge clk);
    frame(1, 20'd1, mem[1], 1'b0);
    check("drain_drop", 32'(exp_q.size()), 32'd0);

`ifdef LOOP_MIX_EN
    // Saturating mix and idle pass-through of the live sample
    mem[0] = 16'd30000;
    mem[1] = 16'h8AD0;
    pulse_start(20'd2);
    live = 16'd10000;
    frame(1, 20'd0, SAMPLE_MAX, 1'b0);
    live = 16'hD8F0;
    frame(1, 20'd1, SAMPLE_MIN, 1'b1);
    live = 16'd500;
    frame(1, 20'd0, 16'd30500, 1'b0);
    pulse_stop();
    live = 16'd1234;
    frame(2, '0, '0, 1'b0);
    live = '0;
    mem[0] = 16'd100;
    mem[1] = 16'd200;
`endif

    // Asynchronous reset in the middle of a read
    pulse_start(20'd4);
    frame(1, 20'd0, mem[0], 1'b0);
    @(negedge clk);
    sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    check("pre_reset_addr", 32'(addr), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ce", 32'(ce_n), 32'd1);
    check("arst_oe", 32'(oe_n), 32'd1);
    check("arst_lb", 32'(lb_n), 32'd1);
    check("arst_ub", 32'(ub_n), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_addr", 32'(addr), 32'd0);
    check("arst_data", 32'(data), 32'd0);
    check("arst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (RW + 4) @(negedge clk);
    check("final_drain", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
